// File: rtl/axi_rd_pattern_slave.sv
// AXI4 read-only slave returning generated RGB565 test-pattern beats for frame-buffer bursts.
// In-order AR queue, configurable first-beat latency and inter-beat gap, honours RREADY.
module axi_rd_pattern_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned PLANE_WORDS = 9600,
    parameter int unsigned AR_DEPTH    = 4,
    parameter int unsigned FIRST_LAT   = 1,
    parameter int unsigned BEAT_GAP    = 0
) (
    input  logic              AXI_ACLK,
    input  logic              AXI_ARESET,
    input  logic [ID_W-1:0]   S_AXI_ARID,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [7:0]        S_AXI_ARLEN,
    input  logic [2:0]        S_AXI_ARSIZE,
    input  logic [1:0]        S_AXI_ARBURST,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [ID_W-1:0]   S_AXI_RID,
    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RLAST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic [31:0]       burst_done_cnt,
    output logic              busy
);

    localparam int unsigned LANES     = DATA_W / 16;
    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned SIZE_CODE = $clog2(BYTES);
    localparam int unsigned PTR_W     = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(AR_DEPTH + 1);
    localparam int unsigned TMR_W     = 16;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_t;

    typedef enum logic [1:0] {ST_IDLE, ST_LAT, ST_BEAT, ST_GAP} state_t;

    ar_t               fifo_q [AR_DEPTH];
    ar_t               ar_in;
    ar_t               head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              arready_q, arready_d;
    state_t            state_q, state_d;
    logic [TMR_W-1:0]  lat_q, lat_d, gap_q, gap_d;
    logic              gap_last_q, gap_last_d;
    logic [7:0]        beat_q, beat_d;
    logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       done_q, done_d;
    logic              busy_q, busy_d;
    logic              push, pop, load;

    logic [7:0]        load_idx;
    logic [ADDR_W-1:0] w0, mask, word, col;
    logic [1:0]        plane;
    logic              bad;
    logic [DATA_W-1:0] pix;

    assign ar_in = {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST};
    assign head  = fifo_q[rd_ptr_q];
    assign push  = S_AXI_ARVALID && arready_q;

    // Pattern for the beat about to be presented from the head burst
    always_comb begin
        case (state_q)
            ST_BEAT: load_idx = beat_q + 8'd1;
            ST_GAP:  load_idx = beat_q;
            default: load_idx = 8'd0;
        endcase
        w0   = head.addr >> SIZE_CODE;
        mask = ADDR_W'(head.len);
        case (head.burst)
            2'b00:   word = w0;
            2'b10:   word = (w0 & ~mask) | ((w0 + ADDR_W'(load_idx)) & mask);
            default: word = w0 + ADDR_W'(load_idx);
        endcase
        bad = (head.size != 3'(SIZE_CODE)) || (head.burst == 2'b11) ||
              ((head.burst == 2'b10) && !(head.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        plane = 2'(word / ADDR_W'(PLANE_WORDS));
        col   = word % ADDR_W'(PLANE_WORDS);
        pix   = '0;
        for (int k = 0; k < LANES; k++) begin
            case (plane)
                2'd0:    pix[16*k +: 16] = 16'(col * ADDR_W'(LANES) + ADDR_W'(k));
                2'd1:    pix[16*k +: 16] = 16'h001f;
                2'd2:    pix[16*k +: 16] = 16'h07e0;
                default: pix[16*k +: 16] = 16'hf100;
            endcase
        end
        if (bad) pix = '0;
    end

    // Next-state: queue bookkeeping and burst sequencing
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        gap_d      = gap_q;
        gap_last_d = gap_last_q;
        beat_d     = beat_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        done_d     = done_q;
        pop        = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    beat_d = 8'd0;
                    if (FIRST_LAT <= 1) begin
                        state_d = ST_BEAT;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_LAT;
                        lat_d   = TMR_W'(FIRST_LAT - 2);
                    end
                end
            end
            ST_LAT: begin
                if (lat_q == '0) begin
                    state_d = ST_BEAT;
                    load    = 1'b1;
                end else begin
                    lat_d = lat_q - TMR_W'(1);
                end
            end
            ST_BEAT: begin
                if (S_AXI_RREADY) begin
                    if (rlast_q) begin
                        pop      = 1'b1;
                        done_d   = done_q + 32'd1;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        if (BEAT_GAP == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d    = ST_GAP;
                            gap_d      = TMR_W'(BEAT_GAP - 1);
                            gap_last_d = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                        if (BEAT_GAP == 0) begin
                            load = 1'b1;
                        end else begin
                            rvalid_d   = 1'b0;
                            state_d    = ST_GAP;
                            gap_d      = TMR_W'(BEAT_GAP - 1);
                            gap_last_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                if (gap_q == '0) begin
                    if (gap_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BEAT;
                        load    = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - TMR_W'(1);
                end
            end
        endcase

        if (load) begin
            rvalid_d = 1'b1;
            rdata_d  = pix;
            rresp_d  = bad ? 2'b10 : 2'b00;
            rlast_d  = (load_idx == head.len);
            rid_d    = head.id;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // No bypass: a full queue keeps ARREADY low even while popping
        arready_d = (count_d != CNT_W'(AR_DEPTH));
        busy_d    = (count_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            gap_q      <= '0;
            gap_last_q <= 1'b0;
            beat_q     <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            done_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            arready_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            gap_q      <= gap_d;
            gap_last_q <= gap_last_d;
            beat_q     <= beat_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            arready_q  <= arready_d;
            busy_q     <= busy_d;
        end
    end

    // Queue storage needs no reset; pointers define validity
    always_ff @(posedge AXI_ACLK) begin
        if (push) fifo_q[wr_ptr_q] <= ar_in;
    end

    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_RID      = rid_q;
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = rresp_q;
    assign S_AXI_RLAST    = rlast_q;
    assign S_AXI_RVALID   = rvalid_q;
    assign burst_done_cnt = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_axi_rd_pattern_slave.sv
// Self-checking bench for axi_rd_pattern_slave: directed scenarios plus randomized bursts
// scored against an arithmetic model of the pattern and burst-addressing rules.
module tb_axi_rd_pattern_slave;

    localparam int PW = 9600;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        AXI_ARESET;
    logic [3:0]  S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [3:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] burst_done_cnt;
    logic        busy;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    rr_mode = 1;
    logic  rready_man = 1'b0;
    logic  rready_rand = 1'b0;
    beat_t got_q[$];
    beat_t exp_q[$];

    axi_rd_pattern_slave dut (
        .AXI_ACLK(clk), .AXI_ARESET(AXI_ARESET),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .burst_done_cnt(burst_done_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rready_rand = 1'($urandom_range(0, 1));
    end
    assign S_AXI_RREADY = (rr_mode == 0) ? rready_man : (rr_mode == 1) ? 1'b1 : rready_rand;

    // Record every beat that will be accepted at the next rising edge
    always @(negedge clk) begin
        if (!AXI_ARESET && S_AXI_RVALID && S_AXI_RREADY)
            got_q.push_back('{S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, cyc});
    end

    function automatic beat_t model(input int id, input logic [31:0] addr, input int len,
                                    input int size, input int burst, input int i);
        beat_t  b;
        longint w, n, base, word;
        int     plane, c;
        bit     bad;
        b.id   = 4'(id);
        b.last = (i == len);
        b.cyc  = 0;
        bad = (size != 2) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        w = addr / 4;
        n = len + 1;
        if (burst == 0) word = w;
        else if (burst == 2) begin
            base = (w / n) * n;
            word = base + (w - base + i) % n;
        end else word = w + i;
        plane = int'((word / PW) % 4);
        c     = int'(word % PW);
        if (bad) begin
            b.resp = 2'b10;
            b.data = 32'h0;
        end else begin
            b.resp = 2'b00;
            case (plane)
                0:       b.data = {16'((c * 2 + 1) % 65536), 16'((c * 2) % 65536)};
                1:       b.data = {2{16'h001f}};
                2:       b.data = {2{16'h07e0}};
                default: b.data = {2{16'hf100}};
            endcase
        end
        return b;
    endfunction

    task automatic ar_push(input int id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
        int t = 0;
        S_AXI_ARID    = 4'(id);
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARSIZE  = 3'(size);
        S_AXI_ARBURST = 2'(burst);
        S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        while (!S_AXI_ARREADY && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (S_AXI_ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_accept id=%0d: ARREADY=%b required 1 within %0d cycles", id, S_AXI_ARREADY, t);
        end
        @(posedge clk);
        #1 S_AXI_ARVALID = 1'b0;
        for (int i = 0; i <= len; i++) exp_q.push_back(model(id, addr, len, size, burst, i));
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t = 0;
        while (got_q.size() < n && t < 3000) begin
            @(posedge clk);
            #1 t++;
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != n) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d beats, required %0d", tag, got_q.size(), n);
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        AXI_ARESET = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (S_AXI_ARREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_arready: got %b required 0", S_AXI_ARREADY);
        end
        n_cmp++;
        if ({S_AXI_RVALID, S_AXI_RLAST, busy, S_AXI_RRESP, S_AXI_RID} !== 9'd0 ||
            S_AXI_RDATA !== 32'h0 || burst_done_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rvalid=%b rlast=%b busy=%b rid=%h rdata=%h rresp=%b cnt=%0d required all 0",
                     S_AXI_RVALID, S_AXI_RLAST, busy, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, burst_done_cnt);
        end
        @(posedge clk);
        #1 AXI_ARESET = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (S_AXI_ARREADY !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: arready=%b busy=%b required 1/0", S_AXI_ARREADY, busy);
        end
    endtask

    task automatic test_incr();
        clear_q();
        rr_mode = 1;
        ar_push(3, 32'h0, 19, 2, 1);
        @(negedge clk);
        n_cmp++;
        if (S_AXI_RVALID !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL incr_early: rvalid=%b busy=%b required 0/1", S_AXI_RVALID, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (S_AXI_RVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL incr_latency: rvalid=%b required 1 one cycle after accept", S_AXI_RVALID);
        end
        wait_beats(20, "incr");
        for (int i = 0; i < 20 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].data !== {16'(2 * i + 1), 16'(2 * i)} || got_q[i].last !== (i == 19) ||
                got_q[i].id !== 4'd3 || got_q[i].resp !== 2'b00 || got_q[i].cyc !== got_q[0].cyc + i) begin
                n_fail++;
                $display("FAIL incr beat %0d: got data=%h last=%b id=%0d resp=%b cyc+%0d required data=%h last=%b id=3 resp=0 cyc+%0d",
                         i, got_q[i].data, got_q[i].last, got_q[i].id, got_q[i].resp,
                         got_q[i].cyc - got_q[0].cyc, {16'(2 * i + 1), 16'(2 * i)}, (i == 19), i);
            end
        end
        n_cmp++;
        if (burst_done_cnt !== 32'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_done: cnt=%0d busy=%b required 1/0", burst_done_cnt, busy);
        end
    endtask

    task automatic test_planes();
        logic [31:0] pick [6];
        int          idx  [6];
        clear_q();
        rr_mode = 2;
        ar_push(1, 32'h9600, 3, 2, 1);
        ar_push(2, 32'h12C00, 3, 2, 1);
        ar_push(3, 32'h1C200, 3, 2, 1);
        ar_push(4, 32'h25800, 1, 2, 1);
        ar_push(5, 32'h12BFC, 1, 2, 1);
        wait_beats(exp_q.size(), "planes");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data ||
                got_q[i].resp !== exp_q[i].resp || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL planes beat %0d: got id=%0d data=%h resp=%b last=%b required id=%0d data=%h resp=%b last=%b",
                         i, got_q[i].id, got_q[i].data, got_q[i].resp, got_q[i].last,
                         exp_q[i].id, exp_q[i].data, exp_q[i].resp, exp_q[i].last);
            end
        end
        idx  = '{0, 4, 8, 12, 14, 15};
        pick = '{32'h001f001f, 32'h07e007e0, 32'hf100f100, 32'h00010000, 32'h001f001f, 32'h07e007e0};
        for (int j = 0; j < 6; j++) begin
            if (idx[j] < got_q.size()) begin
                n_cmp++;
                if (got_q[idx[j]].data !== pick[j]) begin
                    n_fail++;
                    $display("FAIL plane_const beat %0d: got %h required %h", idx[j], got_q[idx[j]].data, pick[j]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] snap;
        logic        snap_last;
        clear_q();
        rready_man = 1'b0;
        rr_mode    = 0;
        ar_push(2, 32'h40, 5, 2, 1);
        for (int b = 0; b < 6; b++) begin
            for (int t = 0; t < 50 && !S_AXI_RVALID; t++) begin
                @(posedge clk);
                #1;
            end
            if (b == 2) begin
                snap      = S_AXI_RDATA;
                snap_last = S_AXI_RLAST;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    n_cmp++;
                    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== snap || S_AXI_RLAST !== snap_last) begin
                        n_fail++;
                        $display("FAIL hold: rvalid=%b rdata=%h rlast=%b required 1/%h/%b",
                                 S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, snap, snap_last);
                    end
                end
            end
            rready_man = 1'b1;
            @(posedge clk);
            #1 rready_man = 1'b0;
        end
        wait_beats(6, "backpressure");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last || got_q[i].id !== exp_q[i].id) begin
                n_fail++;
                $display("FAIL backpressure beat %0d: got data=%h last=%b id=%0d required data=%h last=%b id=%0d",
                         i, got_q[i].data, got_q[i].last, got_q[i].id, exp_q[i].data, exp_q[i].last, exp_q[i].id);
            end
        end
        rr_mode = 1;
    endtask

    task automatic test_outstanding();
        logic [31:0] a5;
        clear_q();
        rready_man = 1'b0;
        rr_mode    = 0;
        for (int k = 1; k <= 4; k++) ar_push(k, 32'($urandom_range(0, 100000)) & 32'hFFFF_FFFC, 1, 2, 1);
        n_cmp++;
        if (S_AXI_ARREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL full_arready: got %b required 0 with 4 queued", S_AXI_ARREADY);
        end
        a5 = 32'($urandom_range(0, 100000)) & 32'hFFFF_FFFC;
        S_AXI_ARID    = 4'd5;
        S_AXI_ARADDR  = a5;
        S_AXI_ARLEN   = 8'd1;
        S_AXI_ARSIZE  = 3'd2;
        S_AXI_ARBURST = 2'd1;
        S_AXI_ARVALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (S_AXI_ARREADY !== 1'b0 || S_AXI_RVALID !== 1'b1) begin
                n_fail++;
                $display("FAIL full_hold: arready=%b rvalid=%b required 0/1", S_AXI_ARREADY, S_AXI_RVALID);
            end
        end
        rr_mode = 2;
        ar_push(5, a5, 1, 2, 1);
        wait_beats(10, "outstanding");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].id !== 4'(i / 2 + 1) || got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL order beat %0d: got id=%0d data=%h last=%b required id=%0d data=%h last=%b",
                         i, got_q[i].id, got_q[i].data, got_q[i].last, i / 2 + 1, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] cnt0;
        clear_q();
        rr_mode = 2;
        cnt0 = burst_done_cnt;
        ar_push(1, 32'h40, 1, 3, 1);
        ar_push(2, 32'h80, 2, 2, 3);
        ar_push(3, 32'hC0, 2, 2, 2);
        ar_push(4, 32'h100, 0, 1, 0);
        wait_beats(exp_q.size(), "error");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data ||
                got_q[i].resp !== exp_q[i].resp || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL error beat %0d: got id=%0d data=%h resp=%b last=%b required id=%0d data=%h resp=%b last=%b",
                         i, got_q[i].id, got_q[i].data, got_q[i].resp, got_q[i].last,
                         exp_q[i].id, exp_q[i].data, exp_q[i].resp, exp_q[i].last);
            end
        end
        if (got_q.size() >= 2) begin
            n_cmp++;
            if (got_q[0].resp !== 2'b10 || got_q[1].resp !== 2'b10 || got_q[0].data !== 32'h0 ||
                got_q[1].data !== 32'h0 || got_q[0].last !== 1'b0 || got_q[1].last !== 1'b1) begin
                n_fail++;
                $display("FAIL slverr_size: resp=%b,%b data=%h,%h last=%b,%b required 10,10 0,0 0,1",
                         got_q[0].resp, got_q[1].resp, got_q[0].data, got_q[1].data, got_q[0].last, got_q[1].last);
            end
        end
        n_cmp++;
        if (burst_done_cnt !== cnt0 + 32'd4) begin
            n_fail++;
            $display("FAIL error_cnt: got %0d required %0d", burst_done_cnt, cnt0 + 32'd4);
        end
    endtask

    task automatic test_wrap_reset();
        int wexp [4];
        clear_q();
        rr_mode = 1;
        wexp = '{2, 3, 0, 1};
        ar_push(6, 32'h8, 3, 2, 2);
        wait_beats(4, "wrap");
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].data !== {16'(2 * wexp[i] + 1), 16'(2 * wexp[i])} || got_q[i].last !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap beat %0d: got data=%h last=%b required data=%h last=%b", i,
                         got_q[i].data, got_q[i].last, {16'(2 * wexp[i] + 1), 16'(2 * wexp[i])}, (i == 3));
            end
        end
        clear_q();
        ar_push(7, 32'h100, 15, 2, 1);
        ar_push(8, 32'h200, 3, 2, 1);
        for (int t = 0; t < 100 && got_q.size() < 3; t++) begin
            @(posedge clk);
            #1;
        end
        AXI_ARESET = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (S_AXI_RVALID !== 1'b0 || busy !== 1'b0 || S_AXI_ARREADY !== 1'b0 || burst_done_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset: rvalid=%b busy=%b arready=%b cnt=%0d required 0/0/0/0",
                     S_AXI_RVALID, busy, S_AXI_ARREADY, burst_done_cnt);
        end
        AXI_ARESET = 1'b0;
        clear_q();
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 0 || busy !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped: beats=%0d busy=%b arready=%b required 0/0/1", got_q.size(), busy, S_AXI_ARREADY);
        end
        ar_push(9, 32'h1234, 0, 2, 0);
        wait_beats(1, "single");
        if (got_q.size() >= 1) begin
            n_cmp++;
            if (got_q[0].last !== 1'b1 || got_q[0].id !== 4'd9 || got_q[0].data !== exp_q[0].data ||
                burst_done_cnt !== 32'd1) begin
                n_fail++;
                $display("FAIL single: last=%b id=%0d data=%h cnt=%0d required 1/9/%h/1",
                         got_q[0].last, got_q[0].id, got_q[0].data, exp_q[0].data, burst_done_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] cnt0;
        int          r, len, size, burst;
        clear_q();
        rr_mode = 2;
        cnt0 = burst_done_cnt;
        for (int k = 0; k < 16; k++) begin
            r     = int'($urandom_range(0, 7));
            len   = int'($urandom_range(0, 15));
            size  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 2;
            burst = (r == 0) ? 0 : (r <= 4) ? 1 : (r <= 6) ? 2 : 3;
            if (r == 5) len = (1 << $urandom_range(1, 4)) - 1;
            ar_push(int'($urandom_range(0, 15)), 32'($urandom_range(0, 4 * PW * 5 - 1)), len, size, burst);
        end
        wait_beats(exp_q.size(), "random");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data ||
                got_q[i].resp !== exp_q[i].resp || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL random beat %0d: got id=%0d data=%h resp=%b last=%b required id=%0d data=%h resp=%b last=%b",
                         i, got_q[i].id, got_q[i].data, got_q[i].resp, got_q[i].last,
                         exp_q[i].id, exp_q[i].data, exp_q[i].resp, exp_q[i].last);
            end
        end
        n_cmp++;
        if (burst_done_cnt !== cnt0 + 32'd16) begin
            n_fail++;
            $display("FAIL random_cnt: got %0d required %0d", burst_done_cnt, cnt0 + 32'd16);
        end
    endtask

    initial begin
        AXI_ARESET    = 1'b1;
        S_AXI_ARID    = '0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARLEN   = '0;
        S_AXI_ARSIZE  = '0;
        S_AXI_ARBURST = '0;
        S_AXI_ARVALID = 1'b0;
        test_reset();
        test_incr();
        test_planes();
        test_backpressure();
        test_outstanding();
        test_error();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
